// File: rtl/dp2_pkg.sv
// Shared constants for the datapath2 slice: default data width and the
// all-ones value that the saturating add clamps to.
package dp2_pkg;

   localparam int DP2_WIDTH = 8;
   localparam logic [DP2_WIDTH-1:0] DP2_MAX = '1;

endpackage : dp2_pkg

// File: rtl/datapath2_if.sv
// Operand/result bundle for datapath2. The master drives operands and
// control, the slave (the datapath) returns the three registered values.
interface datapath2_if #(
   parameter int WIDTH = dp2_pkg::DP2_WIDTH
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ld;
   logic             clr;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic [WIDTH-1:0] out_c;

   modport master (
      output a, b, ld, clr,
      input  out_a, out_b, out_c
   );

   modport slave (
      input  a, b, ld, clr,
      output out_a, out_b, out_c
   );

endinterface : datapath2_if

// File: rtl/dp2_adder.sv
// Combinational unsigned adder for datapath2.
// Default: WIDTH-bit wrapping add, carry discarded.
// With DATAPATH2_SAT_EN defined: saturating add, clamps to all ones on carry.
module dp2_adder #(
   parameter int WIDTH = dp2_pkg::DP2_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

`ifdef DATAPATH2_SAT_EN
   logic [WIDTH:0] full_sum;

   // Extend by one bit so the carry-out is visible, then clamp on carry.
   always_comb begin
      full_sum = {1'b0, a} + {1'b0, b};
      sum      = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
   end
`else
   // Plain modulo-2^WIDTH add; the carry simply falls off the top.
   always_comb begin
      sum = a + b;
   end
`endif

endmodule : dp2_adder

// File: rtl/datapath2.sv
// datapath2: two operand registers feeding an adder whose result is
// registered again, so outA/outB lag A/B by one edge and outC by two.
// Optional build macro: DATAPATH2_SAT_EN selects a saturating add.
module datapath2
   import dp2_pkg::*;
#(
   parameter int WIDTH = DP2_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ld,
   input  logic             clr,
   input  logic             clk,
   output logic [WIDTH-1:0] outA,
   output logic [WIDTH-1:0] outB,
   output logic [WIDTH-1:0] outC
);

   logic [WIDTH-1:0] sum;

   dp2_adder #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a   (outA),
      .b   (outB),
      .sum (sum)
   );

   // Operand and result registers; clr wins over ld, outC updates every edge.
   always_ff @(posedge clk) begin
      // NOTE: clr is sampled only at the clock edge, and all state uses <= so
      // outC sees the pre-edge operand registers, not the ones loaded now.
      if (!clr) begin
         outA <= '0;
         outB <= '0;
         outC <= '0;
      end else begin
         if (ld) begin
            outA <= A;
            outB <= B;
         end
         outC <= sum;
      end
   end

endmodule : datapath2

// File: tb/tb_datapath2.sv
// Directed bench for datapath2: a table of one-edge vectors followed by a
// hand-written mid-stream reset sequence. Expected values are hand-derived;
// the two overflow results depend on DATAPATH2_SAT_EN.
module tb_datapath2;
   import dp2_pkg::*;

   localparam int W = DP2_WIDTH;

`ifdef DATAPATH2_SAT_EN
   localparam logic [W-1:0] OV1 = DP2_MAX;   // 253 + 30 clamps
   localparam logic [W-1:0] OV2 = DP2_MAX;   // 230 + 255 clamps
`else
   localparam logic [W-1:0] OV1 = 8'd27;     // 283 mod 256
   localparam logic [W-1:0] OV2 = 8'd229;    // 485 mod 256
`endif

   typedef struct {
      string        name;
      logic         clr;
      logic         ld;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_a;
      logic [W-1:0] exp_b;
      logic [W-1:0] exp_c;
   } vec_t;

   logic clk;
   int   n_vec;
   int   n_bad;

   datapath2_if #(.WIDTH(W)) bus ();

   datapath2 #(
      .WIDTH (W)
   ) dut (
      .A    (bus.a),
      .B    (bus.b),
      .ld   (bus.ld),
      .clr  (bus.clr),
      .clk  (clk),
      .outA (bus.out_a),
      .outB (bus.out_b),
      .outC (bus.out_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] actual,
                        input logic [W-1:0] expected);
      n_vec = n_vec + 1;
      if (actual !== expected) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic drive(input logic clr, input logic ld,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      bus.clr = clr;
      bus.ld  = ld;
      bus.a   = a;
      bus.b   = b;
   endtask

   // Advance one rising edge and move off it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic [W-1:0] ea,
                            input logic [W-1:0] eb, input logic [W-1:0] ec);
      check({name, ".outA"}, bus.out_a, ea);
      check({name, ".outB"}, bus.out_b, eb);
      check({name, ".outC"}, bus.out_c, ec);
   endtask

   vec_t vecs [14];

   initial begin
      n_vec = 0;
      n_bad = 0;
      drive(1'b0, 1'b1, 8'd9, 8'd2);

      //          name          clr   ld    A          B       outA    outB    outC
      vecs[0]  = '{"rst0",      1'b0, 1'b1, 8'd9,      8'd2,   8'd0,   8'd0,   8'd0};
      vecs[1]  = '{"rst1",      1'b0, 1'b1, 8'd9,      8'd2,   8'd0,   8'd0,   8'd0};
      vecs[2]  = '{"load9_2",   1'b1, 1'b1, 8'd9,      8'd2,   8'd9,   8'd2,   8'd0};
      vecs[3]  = '{"load20_4",  1'b1, 1'b1, 8'd20,     8'd4,   8'd20,  8'd4,   8'd11};
      vecs[4]  = '{"hold0",     1'b1, 1'b0, 8'd7,      8'd7,   8'd20,  8'd4,   8'd24};
      vecs[5]  = '{"hold1",     1'b1, 1'b0, 8'd7,      8'd7,   8'd20,  8'd4,   8'd24};
      vecs[6]  = '{"hold2",     1'b1, 1'b0, 8'd7,      8'd7,   8'd20,  8'd4,   8'd24};
      vecs[7]  = '{"ovf_ld1",   1'b1, 1'b1, 8'(-3),    8'd30,  8'd253, 8'd30,  8'd24};
      vecs[8]  = '{"ovf_ld2",   1'b1, 1'b1, 8'd230,    8'd255, 8'd230, 8'd255, OV1};
      vecs[9]  = '{"ovf_res2",  1'b1, 1'b0, 8'd0,      8'd0,   8'd230, 8'd255, OV2};
      vecs[10] = '{"b2b_0_0",   1'b1, 1'b1, 8'd0,      8'd0,   8'd0,   8'd0,   OV2};
      vecs[11] = '{"b2b_9_2",   1'b1, 1'b1, 8'd9,      8'd2,   8'd9,   8'd2,   8'd0};
      vecs[12] = '{"b2b_20_4",  1'b1, 1'b1, 8'd20,     8'd4,   8'd20,  8'd4,   8'd11};
      vecs[13] = '{"b2b_drain", 1'b1, 1'b0, 8'd0,      8'd0,   8'd20,  8'd4,   8'd24};

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].clr, vecs[i].ld, vecs[i].a, vecs[i].b);
         tick();
         check_all(vecs[i].name, vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_c);
      end

      // Mid-stream reset: a 9+2 sum is in flight when clr drops for one edge.
      drive(1'b1, 1'b1, 8'd9, 8'd2);
      tick();
      check_all("mid_load", 8'd9, 8'd2, 8'd24);
      drive(1'b0, 1'b1, 8'd50, 8'd50);
      tick();
      check_all("mid_rst", 8'd0, 8'd0, 8'd0);
      drive(1'b1, 1'b1, 8'd1, 8'd1);
      tick();
      check_all("mid_after", 8'd1, 8'd1, 8'd0);

      // A clr pulse that starts and ends between edges must do nothing.
      drive(1'b1, 1'b0, 8'd0, 8'd0);
      bus.clr = 1'b0;
      #2;
      bus.clr = 1'b1;
      tick();
      check_all("clr_glitch", 8'd1, 8'd1, 8'd2);
      tick();
      check_all("final_hold", 8'd1, 8'd1, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_datapath2
